// File: rtl/audio_sample_sched.sv
// Audio sample scheduler: buffers IFFT samples in a FIFO and releases them to a
// 1-bit DAC at a fixed sample period. Playback waits for the FIFO to prime to a
// minimum level, then emits one sample per period. When the FIFO runs dry, the
// sample is replaced by silence and the event is counted.
module audio_sample_sched #(
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic [15:0]              period,
  input  logic                     clr_stats,
  input  logic [15:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [15:0]              pcm_out,
  output logic                     stb,
  output logic                     running,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_L = (AW+1)'(PRIME_LVL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic [15:0]      mem [DEPTH];

  logic             push;
  logic             pop;
  logic             tick;
  logic             underrun;
  logic [15:0]      period_eff;
  logic [15:0]      reload_val;
  logic [15:0]      head;

  // Handshake and tick decode. Dropping enable suppresses a tick that would
  // otherwise land on the same edge as the return to IDLE.
  assign s_ready    = (level_q != DEPTH_L);
  assign push       = s_valid && s_ready;
  assign tick       = (state_q == RUN) && enable && (cnt_q == 16'd0);
  assign pop        = tick && (level_q != '0);
  assign underrun   = tick && (level_q == '0);
  assign period_eff = (period < 16'd2) ? 16'd2 : period;
  assign reload_val = period_eff - 16'd1;
  assign head       = mem[rd_ptr];
  assign level      = level_q;

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves level alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + (AW+1)'(1);
      end else if (pop && !push) begin
        level_q <= level_q - (AW+1)'(1);
      end
    end
  end

  // Playback state machine with the period counter and registered DAC outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      pcm_out <= 16'h0000;
      stb     <= 1'b0;
      running <= 1'b0;
    end else begin
      stb <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        running <= 1'b0;
        cnt_q   <= 16'd0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= PRIME;
          end
          PRIME: begin
            if (level_q >= PRIME_L) begin
              state_q <= RUN;
              running <= 1'b1;
              cnt_q   <= reload_val;
            end
          end
          RUN: begin
            if (tick) begin
              cnt_q   <= reload_val;
              stb     <= 1'b1;
              pcm_out <= pop ? head : 16'h0000;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            running <= 1'b0;
            cnt_q   <= 16'd0;
          end
        endcase
      end
    end
  end

  // Saturating underrun statistic; a clear wins over a coincident underrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underrun_cnt <= 8'd0;
    end else if (clr_stats) begin
      underrun_cnt <= 8'd0;
    end else if (underrun && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_sample_sched.sv
// Directed testbench for audio_sample_sched: priming, playback cadence, underrun
// handling, backpressure, degenerate periods, disable/reset and saturation.
module tb_audio_sample_sched;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [15:0] period;
  logic        clr_stats;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] pcm_out;
  logic        stb;
  logic        running;
  logic [4:0]  level;
  logic [7:0]  underrun_cnt;

  int testsRun    = 0;
  int testsFailed = 0;
  int accepted;
  int stbSeen;
  int misses;
  int gap;

  audio_sample_sched #(
    .DEPTH     (16),
    .PRIME_LVL (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .period       (period),
    .clr_stats    (clr_stats),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .pcm_out      (pcm_out),
    .stb          (stb),
    .running      (running),
    .level        (level),
    .underrun_cnt (underrun_cnt)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one input sample for a single clock
  task automatic applyStimulus(input logic valid, input logic [15:0] data);
    s_valid = valid;
    s_data  = data;
    step();
    s_valid = 1'b0;
  endtask

  // Step until stb is seen or the budget runs out, reporting cycles taken
  task automatic waitStb(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (stb !== 1'b1 && cycles < budget);
  endtask

  // Wait for the next strobe and check its spacing and sample value
  task automatic expectSample(input string tag, input int expGap, input logic [15:0] expData);
    int c;
    waitStb(30, c);
    checkOutput({tag, "_gap"}, c, expGap);
    checkOutput({tag, "_data"}, pcm_out, expData);
  endtask

  // Hard stop if the run ever wanders off
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    rstn      = 1'b0;
    enable    = 1'b0;
    period    = 16'd4;
    clr_stats = 1'b0;
    s_valid   = 1'b0;
    s_data    = 16'h0000;
    repeat (2) step();

    checkOutput("rst_level",    level, 0);
    checkOutput("rst_s_ready",  s_ready, 1);
    checkOutput("rst_running",  running, 0);
    checkOutput("rst_stb",      stb, 0);
    checkOutput("rst_pcm",      pcm_out, 0);
    checkOutput("rst_underrun", underrun_cnt, 0);

    rstn = 1'b1;
    step();

    // Prime and run: playback waits for eight samples, then one every 4 cycles
    enable = 1'b1;
    repeat (3) step();
    checkOutput("prime_wait_running", running, 0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i));
    checkOutput("prime_level", level, 8);
    checkOutput("prime_running_pre", running, 0);
    step();
    checkOutput("run_entry", running, 1);
    for (int i = 1; i <= 8; i++) expectSample($sformatf("run%0d", i), 4, 16'(i));
    checkOutput("run_level_empty", level, 0);

    // Underrun: silence is emitted, counted, and playback stays running
    expectSample("underrun", 4, 16'h0000);
    checkOutput("underrun_cnt1", underrun_cnt, 1);
    checkOutput("underrun_running", running, 1);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checkOutput("clr_stats", underrun_cnt, 0);
    step();
    step();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checkOutput("clr_tick_stb", stb, 1);
    checkOutput("clr_tick_cnt", underrun_cnt, 0);

    // Backpressure: only sixteen of twenty held-valid samples are accepted
    enable   = 1'b0;
    accepted = 0;
    stbSeen  = 0;
    for (int i = 1; i <= 20; i++) begin
      if (s_ready) accepted++;
      applyStimulus(1'b1, 16'h1000 + 16'(i));
      if (stb) stbSeen++;
    end
    checkOutput("full_accepted", accepted, 16);
    checkOutput("full_level", level, 16);
    checkOutput("full_s_ready", s_ready, 0);
    checkOutput("full_running", running, 0);
    checkOutput("full_no_stb", stbSeen, 0);

    enable = 1'b1;
    expectSample("drain1", 6, 16'h1001);
    expectSample("drain2", 4, 16'h1002);
    expectSample("drain3", 4, 16'h1003);
    expectSample("drain4", 4, 16'h1004);
    checkOutput("drain_level", level, 12);
    checkOutput("drain_s_ready", s_ready, 1);

    // Disable mid-run: strobes stop, output holds, FIFO is retained
    enable  = 1'b0;
    stbSeen = 0;
    repeat (10) begin
      step();
      if (stb) stbSeen++;
    end
    checkOutput("dis_running", running, 0);
    checkOutput("dis_no_stb", stbSeen, 0);
    checkOutput("dis_pcm_hold", pcm_out, 16'h1004);
    checkOutput("dis_level", level, 12);

    // Degenerate periods clamp to two cycles; a new period applies after the next reload
    period = 16'd0;
    enable = 1'b1;
    expectSample("p0_first", 4, 16'h1005);
    expectSample("p0_a", 2, 16'h1006);
    expectSample("p0_b", 2, 16'h1007);
    expectSample("p0_c", 2, 16'h1008);
    period = 16'd1;
    expectSample("p1_a", 2, 16'h1009);
    expectSample("p1_b", 2, 16'h100A);
    expectSample("p1_c", 2, 16'h100B);
    expectSample("p1_d", 2, 16'h100C);
    period = 16'd6;
    expectSample("p6_old", 2, 16'h100D);
    expectSample("p6_new", 6, 16'h100E);
    checkOutput("p6_level", level, 2);

    // Reset while running clears everything immediately
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mrst_running", running, 0);
    checkOutput("mrst_stb", stb, 0);
    checkOutput("mrst_pcm", pcm_out, 0);
    checkOutput("mrst_level", level, 0);
    checkOutput("mrst_s_ready", s_ready, 1);
    checkOutput("mrst_underrun", underrun_cnt, 0);
    @(posedge clk);
    #3;
    rstn    = 1'b1;
    stbSeen = 0;
    repeat (20) begin
      step();
      if (stb) stbSeen++;
    end
    checkOutput("post_rst_no_stb", stbSeen, 0);
    checkOutput("post_rst_running", running, 0);
    checkOutput("post_rst_level", level, 0);

    // Saturation: 8 real samples followed by 300 underruns
    period = 16'd0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'hA5A5);
    misses = 0;
    for (int k = 0; k < 308; k++) begin
      waitStb(20, gap);
      if (stb !== 1'b1) misses++;
      if (k == 261) checkOutput("sat_254", underrun_cnt, 254);
    end
    checkOutput("sat_misses", misses, 0);
    checkOutput("sat_cnt", underrun_cnt, 255);
    checkOutput("sat_pcm", pcm_out, 0);
    checkOutput("sat_running", running, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/audio_sample_sched.md
AUDIO_SAMPLE_SCHED -- requirements
Module: audio_sample_sched

Interface
REQ-001 Parameter DEPTH, default 16: sample FIFO depth in entries; power of two, 4 to 64.
REQ-002 Parameter PRIME_LVL, default 8: FIFO level required before playback starts; 1 to DEPTH.
REQ-003 Port clk  input  1: system clock, 100 MHz; all logic on its rising edge.
REQ-004 Port rstn  input  1: asynchronous, active-low reset.
REQ-005 Port enable  input  1: playback enable, level-sensitive.
REQ-006 Port period  input  16: system-clock cycles per output sample, e.g. 2083 for 48 kHz.
REQ-007 Port clr_stats  input  1: one-cycle pulse that clears underrun_cnt.
REQ-008 Port s_data  input  16: IFFT sample, two's complement.
REQ-009 Port s_valid  input  1: s_data is valid.
REQ-010 Port s_ready  output  1: FIFO can accept a sample.
REQ-011 Port pcm_out  output  16: sample presented to the 1-bit DAC.
REQ-012 Port stb  output  1: one-cycle load strobe for the DAC, coincident with the pcm_out update.
REQ-013 Port running  output  1: high when the state is RUN.
REQ-014 Port level  output  log2(DEPTH)+1: current FIFO occupancy.
REQ-015 Port underrun_cnt  output  8: saturating underrun counter.

Function
REQ-016 The FIFO shall accept a push when s_valid and s_ready are both high; s_ready shall equal (level != DEPTH).
REQ-017 Read and write pointers shall wrap modulo DEPTH; level shall be 0 to DEPTH inclusive.
REQ-018 The state machine shall use three states: IDLE, PRIME and RUN.
REQ-019 IDLE->PRIME when enable=1; PRIME->RUN when enable=1 and level>=PRIME_LVL; any state->IDLE when enable=0 (takes priority).
REQ-020 The period counter shall load period_eff-1 on entry to RUN and decrement each cycle; at 0 it shall raise an internal tick and reload period_eff-1.
REQ-021 period_eff shall equal max(period, 2); period is sampled at each reload, so changes take effect from the next sample.
REQ-022 On tick with level>0: on the next edge, pcm_out <= FIFO head, the entry is popped, and stb=1 for exactly one cycle.
REQ-023 On tick with level=0 (underrun): on the next edge, pcm_out <= 16'h0000, stb=1, and underrun_cnt increments, saturating at 255; the state remains RUN.
REQ-024 A push and a pop in the same cycle shall leave level unchanged; a push in the same cycle as a tick on an empty FIFO is an underrun, and the pushed sample is stored.
REQ-025 The first stb after entering RUN shall occur exactly period_eff cycles after the RUN entry edge.
REQ-026 Outside RUN, stb shall be 0 and pcm_out shall hold its last value; FIFO contents are retained across IDLE and PRIME.
REQ-027 Writes continue in every state while s_ready=1.
REQ-028 clr_stats shall zero underrun_cnt on the next edge; a simultaneous underrun is not counted.
REQ-029 stb shall never be high in two consecutive cycles.

Reset
REQ-030 While rstn=0: state=IDLE, FIFO empty (level=0), pointers=0, counter=0, pcm_out=0, stb=0, running=0, underrun_cnt=0, s_ready=1.
REQ-031 Reset asserted mid-operation shall discard FIFO contents and abort any pending tick; no stb shall follow the reset release until PRIME completes again.

Verification
REQ-032 Prime and run: period=4, PRIME_LVL=8, push 8 samples 1..8, enable=1 -> running rises once level=8, stb every 4 cycles, pcm_out sequence 1..8.
REQ-033 Underrun: continue the REQ-032 run with no pushes -> 9th stb carries 0, underrun_cnt=1, running stays 1; clr_stats -> underrun_cnt=0.
REQ-034 Full/backpressure: enable=0, push 20 samples with s_valid held high -> level=16, s_ready=0, exactly 16 accepted; enabling then drains them in order.
REQ-035 Degenerate period: period=0 and period=1 -> stb every 2 cycles, never on consecutive cycles.
REQ-036 Disable and reset mid-run: drop enable -> stb stops, pcm_out holds, FIFO retained; pulse rstn=0 while running -> all outputs at reset values, level=0.
REQ-037 Saturation: 300 underruns -> underrun_cnt=255.
